// File: rtl/uart_rx.sv
// 8N1 serial receiver: 16x oversampled deframer feeding a first-word-fall-through byte FIFO.
// Framing errors and FIFO overflows are reported as single-cycle pulses.
module uart_rx #(
  parameter int SYS_CLK_FREQ   = 50000000,
  parameter int BAUD_RATE      = 38400,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TICK_DIV = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam int DEPTH    = 1 << FIFO_ADDR_BITS;
  localparam int CNT_W    = FIFO_ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic                      rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0]          div_q, div_d;
  logic                      tick;
  state_t                    state_q, state_d;
  logic [3:0]                os_q, os_d;
  logic [2:0]                bi_q, bi_d;
  logic [7:0]                shift_q, shift_d;
  logic                      push;
  logic                      frame_err_q, frame_err_d;
  logic                      overflow_q, overflow_d;
  logic [7:0]                mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      fifo_empty, fifo_full, do_push, do_pop;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  always_comb begin
    state_d     = state_q;
    os_d        = os_q;
    bi_d        = bi_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            state_d = S_START;
            os_d    = '0;
          end
        end
        S_START: begin
          if (os_q == 4'd7) begin
            if (!rx_sync_q) begin
              state_d = S_DATA;
              os_d    = '0;
              bi_d    = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            os_d = os_q + 4'd1;
          end
        end
        S_DATA: begin
          os_d = os_q + 4'd1;
          if (os_q == 4'd15) begin
            shift_d = {rx_sync_q, shift_q[7:1]};
            if (bi_q == 3'd7) state_d = S_STOP;
            else              bi_d    = bi_q + 3'd1;
          end
        end
        S_STOP: begin
          os_d = os_q + 4'd1;
          if (os_q == 4'd15) begin
            if (rx_sync_q) begin
              push    = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_sync_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a byte when the reader frees a slot in the same cycle.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign do_pop     = rd_en && !fifo_empty;
  assign do_push    = push && (!fifo_full || rd_en);
  assign overflow_d = push && fifo_full && !rd_en;
  assign wr_ptr_d   = do_push ? wr_ptr_q + FIFO_ADDR_BITS'(1) : wr_ptr_q;
  assign rd_ptr_d   = do_pop  ? rd_ptr_q + FIFO_ADDR_BITS'(1) : rd_ptr_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      state_q     <= S_IDLE;
      os_q        <= '0;
      bi_q        <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      state_q     <= state_d;
      os_q        <= os_d;
      bi_q        <= bi_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  // Head is masked while empty so the unreset storage never leaks onto rd_data.
  assign rd_data   = fifo_empty ? 8'h00 : mem[rd_ptr_q];
  assign empty     = fifo_empty;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus serializes bytes and predicts FIFO contents and
// error pulse counts; a negedge monitor checks every read and tallies pulses.
module tb_uart_rx;

  localparam int CLK_HZ = 640000;
  localparam int BAUD   = 10000;
  localparam int TICK   = CLK_HZ / (BAUD * 16);
  localparam int BIT    = TICK * 16;
  localparam int DEPTH  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty, frame_err, overflow;

  uart_rx #(
    .SYS_CLK_FREQ(CLK_HZ),
    .BAUD_RATE(BAUD),
    .FIFO_ADDR_BITS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk = 0, n_pass = 0;
  int act_ferr = 0, act_ovf = 0, exp_ferr = 0, exp_ovf = 0;
  int rel_cyc = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_b;

  function automatic void chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endfunction

  // Monitor: compares every read against the model head and counts error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) act_ferr++;
      if (overflow) act_ovf++;
      if (rd_en) begin
        if (model_q.size() == 0) begin
          chk("empty_on_idle_read", int'(empty), 1);
        end else begin
          exp_b = model_q.pop_front();
          chk("empty_with_data", int'(empty), 0);
          chk("rd_data", int'(rd_data), int'(exp_b));
          $display("read 0x%02h expected 0x%02h", rd_data, exp_b);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(BIT);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(4);
    chk("reset_empty", int'(empty), 1);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_overflow", int'(overflow), 0);
    rst = 1'b0;
    rel_cyc = cyc;
    model_q.delete();
    $display("reset released at cycle %0d", rel_cyc);
  endtask

  // Predicts the outcome from the model state, then serializes the frame. The stop-bit
  // sample lands 152 oversample ticks after the first tick that sees the synchronized edge.
  task automatic send_byte(input logic [7:0] d, input logic stop_ok, input bit rd_at_push);
    int e, d_edge, p;
    e = cyc;
    d_edge = e + 3;
    while (((d_edge - rel_cyc) % TICK) != 0) d_edge++;
    p = d_edge + 152 * TICK;
    if (!stop_ok) exp_ferr++;
    else if (model_q.size() >= DEPTH && !rd_at_push) exp_ovf++;
    else model_q.push_back(d);
    $display("send 0x%02h stop=%0d read_at_push=%0d", d, stop_ok, rd_at_push);
    fork
      begin
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_ok);
      end
      begin
        if (rd_at_push) begin
          while (cyc != p - 1) begin
            @(posedge clk);
            #1;
          end
          rd_en = 1'b1;
          @(posedge clk);
          #1;
          rd_en = 1'b0;
        end
      end
    join
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      idle(1);
      rd_en = 1'b0;
      idle(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    idle(40);

    // Single frame with fall-through timing around the push.
    fork
      send_byte(8'hA5, 1'b1, 1'b0);
      begin
        repeat (608) @(posedge clk);
        @(negedge clk);
        chk("empty_before_push", int'(empty), 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("empty_after_push", int'(empty), 0);
        chk("rd_data_fwft", int'(rd_data), 8'hA5);
      end
    join
    read_n(1);
    chk("empty_after_pop", int'(empty), 1);

    // Short low glitch must be rejected at the start-bit midpoint.
    rx = 1'b0;
    idle(5 * TICK);
    rx = 1'b1;
    idle(2 * BIT);
    chk("glitch_no_push", int'(empty), 1);
    chk("glitch_no_ferr", act_ferr, exp_ferr);
    send_byte(8'h3C, 1'b1, 1'b0);
    read_n(1);

    // Framing error followed by a held-low line.
    send_byte(8'h55, 1'b0, 1'b0);
    idle(2 * BIT);
    rx = 1'b1;
    idle(2 * BIT);
    chk("break_ferr_count", act_ferr, exp_ferr);
    chk("break_empty", int'(empty), 1);

    // Overflow on the ninth unread byte.
    for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1, 1'b0);
    chk("overflow_count", act_ovf, exp_ovf);
    read_n(8);
    chk("empty_after_drain", int'(empty), 1);

    // Full FIFO with a pop on the push cycle: byte accepted, no overflow.
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    send_byte(8'($urandom), 1'b1, 1'b1);
    chk("full_pop_no_overflow", act_ovf, exp_ovf);
    chk("full_pop_not_empty", int'(empty), 0);
    read_n(8);
    chk("full_pop_empty_after", int'(empty), 1);

    // Reset during the data bits abandons the frame.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    idle(BIT / 2);
    rx = 1'b1;
    do_reset();
    idle(2 * BIT);
    chk("post_reset_empty", int'(empty), 1);
    send_byte(8'hC3, 1'b1, 1'b0);
    read_n(1);
    chk("post_reset_drained", int'(empty), 1);

    // Randomized traffic with sporadic reads and gaps (including back-to-back frames).
    for (int k = 0; k < 24; k++) begin
      send_byte(8'($urandom), 1'b1, 1'b0);
      if ($urandom_range(0, 3) != 0) read_n($urandom_range(0, 3));
      if ($urandom_range(0, 1) != 0) idle($urandom_range(0, 30));
    end
    read_n(model_q.size() + 1);
    chk("final_empty", int'(empty), 1);
    chk("final_ferr_count", act_ferr, exp_ferr);
    chk("final_overflow_count", act_ovf, exp_ovf);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
